// File: rtl/spi_controller_if.sv
// Bundle of the host handshake and SPI pins of spi_controller.
// master: the controller itself; slave: the host/target side.
interface spi_controller_if #(
    parameter int WORD_W = 16
);
    logic              start;
    logic [WORD_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] rx_data;
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sclk, cs_n, mosi
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sclk, cs_n, mosi
    );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 controller: one full-duplex MSB-first frame per start.
// SCLK half-period is CLK_DIV system clocks; all outputs registered.
module spi_controller #(
    parameter int WORD_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    spi_controller_if.master  bus
);
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WORD_W);
    localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_t;

    state_t            state, state_d;
    logic [HW-1:0]     hcnt, hcnt_d;
    logic [BW-1:0]     bcnt, bcnt_d;
    logic [WORD_W-1:0] tx_sh, tx_sh_d;
    logic [WORD_W-1:0] rx_sh, rx_sh_d;
    logic [WORD_W-1:0] rx_q, rx_d;
    logic              sclk_q, sclk_d;
    logic              cs_q, cs_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              half_end;

    assign half_end    = (hcnt == HMAX);

    assign bus.sclk    = sclk_q;
    assign bus.cs_n    = cs_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;

    // State and output registers; reset aborts any frame at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            hcnt   <= '0;
            bcnt   <= '0;
            tx_sh  <= '0;
            rx_sh  <= '0;
            rx_q   <= '0;
            sclk_q <= 1'b0;
            cs_q   <= 1'b1;
            mosi_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            hcnt   <= hcnt_d;
            bcnt   <= bcnt_d;
            tx_sh  <= tx_sh_d;
            rx_sh  <= rx_sh_d;
            rx_q   <= rx_d;
            sclk_q <= sclk_d;
            cs_q   <= cs_d;
            mosi_q <= mosi_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Frame sequencing: next state, counters, shifters and pin values.
    always_comb begin
        state_d = state;
        hcnt_d  = hcnt;
        bcnt_d  = bcnt;
        tx_sh_d = tx_sh;
        rx_sh_d = rx_sh;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    tx_sh_d = bus.tx_data;
                    mosi_d  = bus.tx_data[WORD_W-1];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    hcnt_d  = '0;
                    bcnt_d  = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (half_end) begin
                    hcnt_d  = '0;
                    sclk_d  = 1'b1;
                    state_d = XFER;
                end else begin
                    hcnt_d = hcnt + 1'b1;
                end
            end
            XFER: begin
                if (!half_end) begin
                    hcnt_d = hcnt + 1'b1;
                end else if (!sclk_q) begin
                    hcnt_d = '0;
                    sclk_d = 1'b1;
                end else begin
                    // Falling edge: late-sample miso, then present next bit.
                    hcnt_d  = '0;
                    sclk_d  = 1'b0;
                    rx_sh_d = {rx_sh[WORD_W-2:0], bus.miso};
                    if (bcnt == BMAX) begin
                        mosi_d  = 1'b0;
                        bcnt_d  = '0;
                        state_d = HOLD;
                    end else begin
                        bcnt_d  = bcnt + 1'b1;
                        tx_sh_d = {tx_sh[WORD_W-2:0], 1'b0};
                        mosi_d  = tx_sh[WORD_W-2];
                    end
                end
            end
            HOLD: begin
                if (half_end) begin
                    hcnt_d  = '0;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    rx_d    = rx_sh;
                    state_d = GAP;
                end else begin
                    hcnt_d = hcnt + 1'b1;
                end
            end
            GAP: begin
                if (half_end) begin
                    hcnt_d  = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    hcnt_d = hcnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI mode-0 master (controller) that drives the `sclk`/`cs_n`/`mosi` lines and captures `miso`.
- Used to configure and read back the SNN core's SPI target from on-chip test logic or FPGA-side harnesses.
- Each `start` pulse runs one full-duplex frame of `WORD_W` bits, MSB first, with a programmable SCLK divider.
- Reports completion with a one-cycle `done` pulse and a parallel `rx_data` word.

Parameters:
- `WORD_W`, default 16: bits per frame. Must be >= 2.
- `CLK_DIV`, default 4: system clocks per SCLK half-period. Must be >= 1; >= 4 required when the target synchronizes `sclk` to its own `clk`.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a frame; accepted only when `busy`=0.
- `tx_data`  input  `WORD_W`  word to shift out; latched on the cycle `start` is accepted.
- `busy`  output  1  high from the cycle after acceptance until the end of the inter-frame gap.
- `done`  output  1  one-cycle pulse at frame end; `rx_data` is valid from this cycle.
- `rx_data`  output  `WORD_W`  word captured from `miso`, first bit received in the MSB; holds until the next `done`.
- `sclk`  output  1  SPI clock; idles low.
- `cs_n`  output  1  chip select, active low.
- `mosi`  output  1  controller-to-target data.
- `miso`  input  1  target-to-controller data.

Behaviour:
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `rx_data`=0, `sclk`=0, `cs_n`=1, `mosi`=0, FSM=IDLE, counters=0.
- Reset asserted mid-frame aborts the frame immediately (async): `cs_n`=1, `sclk`=0, no `done` pulse, `rx_data` cleared.
- FSM states: IDLE, SETUP, XFER, HOLD, GAP. A half-period counter counts 0..`CLK_DIV`-1; a bit counter counts 0..`WORD_W`-1.
- IDLE:
  - `start`=1 at edge T0 loads `tx_data` into the shift register.
  - At T0+1: `cs_n`=0, `mosi`=`tx_data`[MSB], `busy`=1, state = SETUP.
  - `start` when `busy`=1 (including the `done` cycle) is ignored; there is no queueing.
- SETUP: after `CLK_DIV` cycles, `sclk` rises at T0+1+`CLK_DIV`; state = XFER.
- XFER:
  - `sclk` toggles every `CLK_DIV` cycles.
  - Rising edge k occurs at T0+1+`CLK_DIV`·(1+2k); falling edge k at T0+1+`CLK_DIV`·(2+2k), for k = 0..`WORD_W`-1.
  - `miso` is sampled at the clk edge that drives `sclk` 1→0 (late sampling, giving the target `CLK_DIV` cycles to settle). The sample is shifted into the receive register LSB; the register shifts left.
  - On falling edges 0..`WORD_W`-2, `mosi` updates to the next `tx_data` bit in the same cycle `sclk` goes low.
  - After falling edge `WORD_W`-1: `mosi` is driven 0, state = HOLD.
- HOLD:
  - `sclk`=0 and `cs_n`=0 for `CLK_DIV` cycles.
  - Then `cs_n`=1, `done`=1 for one cycle, `rx_data` is updated in that same cycle, state = GAP.
  - `done` cycle = T0+1+`CLK_DIV`·(2·`WORD_W`+1).
- GAP: `cs_n` stays high for `CLK_DIV` cycles, then `busy`=0 and state = IDLE. Earliest next acceptance is the cycle `busy` reads 0.
- Frame outcome does not depend on `start` or `tx_data` after acceptance; `tx_data` may change freely.
- `sclk` high and low phases are each exactly `CLK_DIV` cycles; no glitches; `sclk` is never high while `cs_n`=1.

Test Plan:
- `WORD_W`=16, `CLK_DIV`=2, `tx_data`=16'hA53C, `start` at T0, target loops back `mosi` to `miso` with 1-bit lag:
  - `cs_n` falls at T0+1, first `sclk` rise at T0+3, last fall at T0+65.
  - `done` at T0+67, `busy` low at T0+69.
  - `mosi` bit sequence 1010_0101_0011_1100.
- Target model drives `miso` pattern 16'h00FF (changing after each falling edge) → `rx_data`=16'h00FF at `done`; 16'hFFFF then 16'h0000 on back-to-back frames → each captured exactly.
- `start` held high continuously → frames repeat, separated by exactly `CLK_DIV` cycles of `cs_n` high. Pulses during `busy` (including the `done` cycle) produce no extra frames; count frames = count `done` pulses.
- `reset` asserted at T0+20 mid-frame → same cycle `cs_n`=1, `sclk`=0, `busy`=0, `rx_data`=0. No `done`. A fresh `start` after release runs a full correct frame.
- `CLK_DIV`=1, `WORD_W`=8, `tx_data`=8'h81 → `sclk` period 2 clocks, `done` at T0+18, `mosi` 1000_0001.
- Change `tx_data` to 16'hFFFF one cycle after acceptance of 16'h0000 → `mosi` stays 0 for the whole frame.
